mem_arbiter: RTL

Shares the core's single-port unified instruction/data memory between the fetch path and the load/store path. It runs one access at a time and grants by priority with alternation. It tracks fixed memory read latency with a counter, returns per-requester valid pulses, and drives the stall signals that freeze PC and pipeline registers while an access is pending.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_grant_sel.sv | 42 ++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: FSM states and access owners.
package mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_grant_sel.sv
// Combinational winner selection: priority to D with alternation when both request,
// and only the non-owner may issue in the ack cycle of the outstanding access.
module mem_arbiter_grant_sel
    import mem_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  state_e state,
    input  owner_e owner,
    input  owner_e last_grant,
    input  logic   ack,
    output logic   grant_valid,
    output owner_e grant_owner
);

    logic other_req;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = 1'b0;
        grant_owner = OWN_I;
        other_req   = (owner == OWN_I) ? d_req : if_req;

        if (state == ST_IDLE) begin
            if (if_req && d_req) begin
                grant_valid = 1'b1;
                grant_owner = (last_grant == OWN_D) ? OWN_I : OWN_D;
            end else if (d_req) begin
                grant_valid = 1'b1;
                grant_owner = OWN_D;
            end else if (if_req) begin
                grant_valid = 1'b1;
                grant_owner = OWN_I;
            end
        end else if (ack && other_req) begin
            // The owner's req is still up for the access that is finishing now.
            grant_valid = 1'b1;
            grant_owner = other_owner(owner);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store traffic onto one single-port memory with a fixed
// read latency, one access outstanding at a time; drives valids and pipeline stalls.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic   ack;
    logic   grant_valid;
    owner_e grant_owner;

    assign ack = (state_q == ST_BUSY) && (cnt_q == CNT_W'(MEM_LAT));

    mem_arbiter_grant_sel u_grant_sel (
        .if_req      (if_req),
        .d_req       (d_req),
        .state       (state_q),
        .owner       (owner_q),
        .last_grant  (last_grant_q),
        .ack         (ack),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        if (grant_valid) begin
            state_d      = ST_BUSY;
            owner_d      = grant_owner;
            last_grant_d = grant_owner;
            cnt_d        = CNT_W'(1);
        end else if (ack) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            cnt_q        <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Every output is forced low during reset, including the purely combinational ones.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_valid  = 1'b0;
        d_valid   = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        if_stall  = 1'b0;
        d_stall   = 1'b0;

        if (rst_n) begin
            if (grant_valid) begin
                mem_en = 1'b1;
                if (grant_owner == OWN_D) begin
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                end else begin
                    mem_addr = if_addr;
                end
            end

            if (ack) begin
                if (owner_q == OWN_I) begin
                    if_valid = 1'b1;
                    if_rdata = mem_rdata;
                end else begin
                    d_valid = 1'b1;
                    d_rdata = mem_rdata;
                end
            end

            if_stall = if_req & ~if_valid;
            d_stall  = d_req & ~d_valid;
        end
    end

endmodule
